// File: rtl/oled_pkg.sv
// Shared constants and state encoding for the OLED frame streamer.
package oled_pkg;

    // Panel geometry (SSD1331, 96x64).
    localparam int OLED_W    = 96;
    localparam int OLED_H    = 64;
    localparam int OLED_NPIX = OLED_W * OLED_H;

    localparam logic [12:0] LAST_PIX = 13'(OLED_NPIX - 1);

    // Window-set preamble: column range command, then row range command.
    localparam logic [7:0] CMD_SET_COL = 8'h15;
    localparam logic [7:0] CMD_SET_ROW = 8'h75;
    localparam int         CMD_LEN     = 6;
    localparam logic [2:0] LAST_CMD    = 3'(CMD_LEN - 1);

    // RGB332 colours.
    localparam logic [7:0] COLOR_GREEN = 8'h1C;
    localparam logic [7:0] COLOR_BLACK = 8'h00;

    typedef enum logic [2:0] {
        IDLE,
        CMD_SEND,
        CMD_WAIT,
        PIX_FETCH,
        PIX_LATCH,
        PIX_SEND,
        PIX_WAIT,
        DONE
    } state_t;

endpackage

// File: rtl/oled_cmd_rom.sv
// Window-set preamble ROM: full-screen column range, then full-screen row range.
module oled_cmd_rom
    import oled_pkg::*;
(
    input  logic [2:0] i_idx,
    output logic [7:0] o_byte
);

    // Combinational lookup of the preamble byte for the given index.
    always_comb begin
        // NOTE: default assignment first so no path leaves o_byte unassigned (no latch).
        o_byte = 8'h00;
        case (i_idx)
            3'd0:    o_byte = CMD_SET_COL;
            3'd1:    o_byte = 8'h00;
            3'd2:    o_byte = 8'(OLED_W - 1);
            3'd3:    o_byte = CMD_SET_ROW;
            3'd4:    o_byte = 8'h00;
            3'd5:    o_byte = 8'(OLED_H - 1);
            default: o_byte = 8'h00;
        endcase
    end

endmodule

// File: rtl/oled_frame_streamer.sv
// Streams one 96x64 frame to the OLED: window-set preamble (command mode),
// then one colour byte per pixel (data mode), row-major, one byte in flight.
module oled_frame_streamer
    import oled_pkg::*;
#(
    parameter logic [7:0] FG_COLOR = COLOR_GREEN,
    parameter logic [7:0] BG_COLOR = COLOR_BLACK
)(
    input  logic        clk,
    input  logic        reset,
    input  logic        init_done,
    input  logic        frame_req,
    output logic        busy,
    output logic        frame_done,
    output logic [12:0] fb_addr,
    input  logic        fb_data,
    output logic        spi_start,
    output logic [7:0]  spi_data,
    input  logic        spi_done,
    output logic        dc
);

    state_t      r_state;
    logic        r_busy;
    logic        r_frame_done;
    logic        r_spi_start;
    logic [7:0]  r_spi_data;
    logic        r_dc;
    logic [12:0] r_pix_cnt;
    logic [2:0]  r_cmd_idx;
    logic [7:0]  w_cmd_byte;

    oled_cmd_rom u_cmd_rom (
        .i_idx  (r_cmd_idx),
        .o_byte (w_cmd_byte)
    );

    // The pixel counter is the read address: it is already valid during
    // PIX_FETCH, so fb_data is ready to be latched in PIX_LATCH.
    assign fb_addr    = r_pix_cnt;
    assign busy       = r_busy;
    assign frame_done = r_frame_done;
    assign spi_start  = r_spi_start;
    assign spi_data   = r_spi_data;
    assign dc         = r_dc;

    // Frame sequencer: FSM, counters and all registered outputs.
    always_ff @(posedge clk) begin
        // NOTE: reset is synchronous, so it is an ordinary branch inside the clocked block.
        if (reset) begin
            r_state      <= IDLE;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
            r_spi_start  <= 1'b0;
            r_spi_data   <= 8'h00;
            r_dc         <= 1'b1;
            r_pix_cnt    <= 13'd0;
            r_cmd_idx    <= 3'd0;
        end else begin
            // NOTE: non-blocking assignments; later ones in the case override these defaults.
            r_spi_start  <= 1'b0;
            r_frame_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (frame_req && init_done) begin
                        r_busy    <= 1'b1;
                        r_cmd_idx <= 3'd0;
                        r_pix_cnt <= 13'd0;
                        r_state   <= CMD_SEND;
                    end
                end
                CMD_SEND: begin
                    r_spi_start <= 1'b1;
                    r_spi_data  <= w_cmd_byte;
                    r_dc        <= 1'b0;
                    r_state     <= CMD_WAIT;
                end
                CMD_WAIT: begin
                    if (spi_done) begin
                        if (r_cmd_idx == LAST_CMD) begin
                            r_pix_cnt <= 13'd0;
                            r_state   <= PIX_FETCH;
                        end else begin
                            r_cmd_idx <= r_cmd_idx + 3'd1;
                            r_state   <= CMD_SEND;
                        end
                    end
                end
                PIX_FETCH: begin
                    r_state <= PIX_LATCH;
                end
                PIX_LATCH: begin
                    r_spi_data <= fb_data ? FG_COLOR : BG_COLOR;
                    r_dc       <= 1'b1;
                    r_state    <= PIX_SEND;
                end
                PIX_SEND: begin
                    r_spi_start <= 1'b1;
                    r_state     <= PIX_WAIT;
                end
                PIX_WAIT: begin
                    if (spi_done) begin
                        if (r_pix_cnt == LAST_PIX) begin
                            // Raised on entry so the pulse lands the cycle after the last spi_done.
                            r_frame_done <= 1'b1;
                            r_state      <= DONE;
                        end else begin
                            r_pix_cnt <= r_pix_cnt + 13'd1;
                            r_state   <= PIX_FETCH;
                        end
                    end
                end
                DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_oled_frame_streamer.sv
// Self-checking bench for oled_frame_streamer: reset/idle vector table,
// request latency, full frame against a byte-stream model, ignored
// requests, spurious spi_done, and reset in the middle of a frame.
module tb_oled_frame_streamer;

    localparam int NPIX = 96 * 64;
    localparam int NCMD = 6;

    logic        clk = 1'b0;
    logic        reset;
    logic        init_done;
    logic        frame_req;
    logic        busy;
    logic        frame_done;
    logic [12:0] fb_addr;
    logic        fb_data;
    logic        spi_start;
    logic [7:0]  spi_data;
    logic        spi_done;
    logic        dc;

    logic model_done;
    logic spur_done;
    logic tbl_done;
    assign spi_done = model_done | spur_done | tbl_done;

    always #5 clk = ~clk;

    oled_frame_streamer dut (
        .clk        (clk),
        .reset      (reset),
        .init_done  (init_done),
        .frame_req  (frame_req),
        .busy       (busy),
        .frame_done (frame_done),
        .fb_addr    (fb_addr),
        .fb_data    (fb_data),
        .spi_start  (spi_start),
        .spi_data   (spi_data),
        .spi_done   (spi_done),
        .dc         (dc)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Frame buffer model: one cycle of read latency.
    bit          fb_mem [0:NPIX-1];
    logic [12:0] fb_rd_addr;
    initial begin
        fb_data = 1'b0;
        forever begin
            @(negedge clk);
            fb_rd_addr = fb_addr;
            @(posedge clk);
            #1;
            fb_data = (fb_rd_addr < 13'(NPIX)) ? fb_mem[fb_rd_addr] : 1'b0;
        end
    end

    // SPI controller model: spi_done a random number of cycles after each start,
    // with an optional spurious spi_done in the cycle after a chosen response.
    int lat_min  = 1;
    int lat_max  = 2;
    int resp_cnt = 0;
    int spur_at  = -1;
    int resp_lat;
    initial begin
        model_done = 1'b0;
        spur_done  = 1'b0;
        forever begin
            @(negedge clk);
            if (spi_start === 1'b1) begin
                resp_lat = $urandom_range(lat_max, lat_min);
                repeat (resp_lat) @(posedge clk);
                #1 model_done = 1'b1;
                @(posedge clk);
                #1 model_done = 1'b0;
                resp_cnt++;
                if (resp_cnt == spur_at) begin
                    spur_done = 1'b1;
                    @(posedge clk);
                    #1 spur_done = 1'b0;
                end
            end
        end
    end

    // Bus monitor: logs bytes, dc and the fb_addr sequence; checks the
    // one-in-flight rule and that dc/spi_data hold until spi_done.
    logic [7:0]  byte_q [$];
    bit          dc_q   [$];
    logic [12:0] addr_q [$];
    int          cyc = 0;
    int          last_done_cyc = -10;
    int          fd_cnt = 0;
    int          fd_cyc = 0;
    int          fd_prev_done = 0;
    bit          outstanding = 1'b0;
    logic [8:0]  held;
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (reset === 1'b1) begin
                outstanding = 1'b0;
            end else begin
                if (spi_done === 1'b1 && outstanding) begin
                    check("hold_until_done", {23'd0, dc, spi_data}, {23'd0, held});
                    outstanding   = 1'b0;
                    last_done_cyc = cyc;
                end
                if (spi_start === 1'b1) begin
                    check("one_in_flight", {31'd0, outstanding}, 32'd0);
                    outstanding = 1'b1;
                    held        = {dc, spi_data};
                    byte_q.push_back(spi_data);
                    dc_q.push_back(dc);
                end
                if (frame_done === 1'b1) begin
                    fd_cnt++;
                    fd_cyc       = cyc;
                    fd_prev_done = last_done_cyc;
                end
                if (busy === 1'b1 && (addr_q.size() == 0 || addr_q[$] != fb_addr))
                    addr_q.push_back(fb_addr);
            end
        end
    end

    // Expected byte stream: preamble in command mode, then one colour byte per pixel.
    logic [7:0] pre [NCMD] = '{8'h15, 8'h00, 8'h5F, 8'h75, 8'h00, 8'h3F};

    task automatic compare_stream(input int npix, input string tag);
        int         n;
        int         mism;
        logic [7:0] e;
        bit         edc;
        n    = NCMD + npix;
        mism = 0;
        check({tag, "_len_ok"}, {31'd0, byte_q.size() >= n}, 32'd1);
        for (int k = 0; k < n && k < byte_q.size(); k++) begin
            e   = (k < NCMD) ? pre[k] : (fb_mem[k - NCMD] ? 8'h1C : 8'h00);
            edc = (k >= NCMD);
            if (byte_q[k] !== e || dc_q[k] !== edc) begin
                if (mism < 5)
                    $display("  byte %0d: got %0h dc %0b, expected %0h dc %0b", k, byte_q[k], dc_q[k], e, edc);
                mism++;
            end
        end
        check({tag, "_bytes"}, mism, 0);
    endtask

    task automatic compare_addrs(input int n, input string tag);
        int mism;
        mism = 0;
        check({tag, "_addr_len"}, addr_q.size(), n);
        for (int k = 0; k < addr_q.size(); k++)
            if (addr_q[k] !== 13'(k)) mism++;
        check({tag, "_addr_seq"}, mism, 0);
    endtask

    typedef struct {
        string      name;
        logic       rst;
        logic       ini;
        logic       req;
        logic       done;
        logic       exp_busy;
        logic       exp_start;
        logic       exp_dc;
        logic [7:0] exp_data;
    } vec_t;

    vec_t vecs [8];
    int   busy_hi;
    int   nb;
    bit   req2_sent;

    initial begin
        reset     = 1'b1;
        init_done = 1'b0;
        frame_req = 1'b0;
        tbl_done  = 1'b0;

        vecs[0] = '{"reset",        1, 0, 0, 0, 0, 0, 1, 8'h00};
        vecs[1] = '{"req_no_init",  0, 0, 1, 0, 0, 0, 1, 8'h00};
        vecs[2] = '{"spur_idle",    0, 0, 0, 1, 0, 0, 1, 8'h00};
        vecs[3] = '{"init_only",    0, 1, 0, 0, 0, 0, 1, 8'h00};
        vecs[4] = '{"accept",       0, 1, 1, 0, 1, 0, 1, 8'h00};
        vecs[5] = '{"first_cmd",    0, 1, 0, 0, 1, 1, 0, 8'h15};
        vecs[6] = '{"reset_cmd",    1, 1, 0, 0, 0, 0, 1, 8'h00};
        vecs[7] = '{"after_reset",  0, 1, 0, 0, 0, 0, 1, 8'h00};

        @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            reset     = vecs[i].rst;
            init_done = vecs[i].ini;
            frame_req = vecs[i].req;
            tbl_done  = vecs[i].done;
            @(posedge clk);
            #1;
            check({vecs[i].name, "_busy"},  {31'd0, busy},      {31'd0, vecs[i].exp_busy});
            check({vecs[i].name, "_start"}, {31'd0, spi_start}, {31'd0, vecs[i].exp_start});
            check({vecs[i].name, "_dc"},    {31'd0, dc},        {31'd0, vecs[i].exp_dc});
            check({vecs[i].name, "_data"},  {24'd0, spi_data},  {24'd0, vecs[i].exp_data});
        end
        reset     = 1'b0;
        frame_req = 1'b0;
        tbl_done  = 1'b0;
        check("reset_fb_addr", {19'd0, fb_addr}, 32'd0);
        check("reset_frame_done", {31'd0, frame_done}, 32'd0);

        // Request without init_done is dropped.
        init_done = 1'b0;
        nb        = byte_q.size();
        busy_hi   = 0;
        frame_req = 1'b1;
        @(posedge clk);
        #1;
        frame_req = 1'b0;
        repeat (100) begin
            @(posedge clk);
            #1;
            if (busy === 1'b1) busy_hi++;
        end
        check("no_init_busy", busy_hi, 0);
        check("no_init_starts", byte_q.size() - nb, 0);

        // Frame A: only the last pixel set, extra request and spurious spi_done mid-frame.
        for (int i = 0; i < NPIX; i++) fb_mem[i] = 1'b0;
        fb_mem[NPIX-1] = 1'b1;
        lat_min  = 1;
        lat_max  = 2;
        resp_cnt = 0;
        spur_at  = NCMD + 50;
        byte_q.delete();
        dc_q.delete();
        addr_q.delete();
        fd_cnt    = 0;
        req2_sent = 1'b0;
        init_done = 1'b1;
        frame_req = 1'b1;
        @(posedge clk);
        #1;
        frame_req = 1'b0;
        check("lat_busy", {31'd0, busy}, 32'd1);
        check("lat_no_start_yet", {31'd0, spi_start}, 32'd0);
        @(posedge clk);
        #1;
        check("lat_start", {31'd0, spi_start}, 32'd1);
        check("lat_byte", {24'd0, spi_data}, 32'h15);
        check("lat_dc", {31'd0, dc}, 32'd0);
        for (int c = 0; c < 60000 && fd_cnt == 0; c++) begin
            @(posedge clk);
            #1;
            frame_req = 1'b0;
            if (!req2_sent && byte_q.size() == NCMD + 100) begin
                frame_req = 1'b1;
                req2_sent = 1'b1;
            end
            if (byte_q.size() == 500) init_done = 1'b0;
        end
        frame_req = 1'b0;
        repeat (10) begin
            @(posedge clk);
            #1;
        end
        check("frameA_done_pulses", fd_cnt, 1);
        check("frameA_done_timing", fd_cyc, fd_prev_done + 1);
        check("frameA_start_count", byte_q.size(), NCMD + NPIX);
        check("frameA_busy_after", {31'd0, busy}, 32'd0);
        check("frameA_last_byte", {24'd0, byte_q[NCMD + NPIX - 1]}, 32'h1C);
        compare_stream(NPIX, "frameA");
        compare_addrs(NPIX, "frameA");

        // Frame B: random picture, reset while waiting on pixel 2000.
        for (int i = 0; i < NPIX; i++) fb_mem[i] = 1'($urandom_range(1, 0));
        lat_min = 1;
        lat_max = 4;
        spur_at = -1;
        byte_q.delete();
        dc_q.delete();
        addr_q.delete();
        fd_cnt    = 0;
        init_done = 1'b1;
        frame_req = 1'b1;
        for (int c = 0; c < 30000 && byte_q.size() < NCMD + 2001; c++) begin
            @(posedge clk);
            #1;
            frame_req = 1'b0;
        end
        check("frameB_reached_2000", {31'd0, byte_q.size() == NCMD + 2001}, 32'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_start", {31'd0, spi_start}, 32'd0);
        check("midrst_dc", {31'd0, dc}, 32'd1);
        check("midrst_data", {24'd0, spi_data}, 32'd0);
        check("midrst_fb_addr", {19'd0, fb_addr}, 32'd0);
        check("midrst_frame_done", {31'd0, frame_done}, 32'd0);
        nb = byte_q.size();
        repeat (20) begin
            @(posedge clk);
            #1;
        end
        check("midrst_silent", byte_q.size() - nb, 0);
        check("midrst_no_done", fd_cnt, 0);
        compare_stream(2001, "frameB");
        compare_addrs(2001, "frameB");

        // Restart after reset begins again with the preamble.
        byte_q.delete();
        dc_q.delete();
        frame_req = 1'b1;
        @(posedge clk);
        #1;
        frame_req = 1'b0;
        check("restart_busy", {31'd0, busy}, 32'd1);
        @(posedge clk);
        #1;
        check("restart_start", {31'd0, spi_start}, 32'd1);
        check("restart_byte", {24'd0, spi_data}, 32'h15);
        for (int c = 0; c < 500 && byte_q.size() < NCMD + 1; c++) begin
            @(posedge clk);
            #1;
        end
        compare_stream(0, "restart");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
